// File: rtl/h_dmux_pkg.sv
// Shared definitions for the Hack base-gate demux family.
// Select encoding lives here so demux trees agree on which leg sel picks.
package h_dmux_pkg;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/h_dmux_if.sv
// Data/select bundle for the 1-to-2 demux: the master drives in/sel, the slave returns a/b.
interface h_dmux_if #(
   parameter int WIDTH = 1
);

   logic [WIDTH-1:0] in;
   logic             sel;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;

   modport master (output in, output sel, input a, input b);
   modport slave  (input in, input sel, output a, output b);

endinterface

// File: rtl/h_dmux_core.sv
// Unregistered 1-to-2 routing core, also reused by the wider DMux4Way/DMux8Way trees.
module hdmux_core
   import h_dmux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] in,
   input  logic             sel,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b
);

   // The unselected leg is forced to zero rather than holding its old value.
   always_comb begin
      a = '0;
      b = '0;
      if (sel == SEL_A) begin
         a = in;
      end else begin
         b = in;
      end
   end

endmodule

// File: rtl/h_dmux.sv
// Registered 1-to-2 demux: hdmux_core followed by an output register with synchronous reset.
module h_dmux
   import h_dmux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic      clk,
   input  logic      reset,
   h_dmux_if.slave   bus
);

   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   hdmux_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .in  (bus.in),
      .sel (bus.sel),
      .a   (a_next),
      .b   (b_next)
   );

   // Reset wins over data on the same edge, so a mid-stream reset discards that cycle's input.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a_next;
         b_q <= b_next;
      end
   end

   assign bus.a = a_q;
   assign bus.b = b_q;

endmodule

// File: tb/tb_h_dmux.sv
// Scoreboard bench for h_dmux, driving a 1-bit and a 16-bit instance in lockstep.
module tb_h_dmux;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   h_dmux_if #(.WIDTH(1))  bus1 ();
   h_dmux_if #(.WIDTH(16)) bus16 ();

   h_dmux #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   h_dmux #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   typedef struct {
      string       tag;
      logic        a1;
      logic        b1;
      logic [15:0] a16;
      logic [15:0] b16;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference: a leg carries the data only when sel names that leg and reset is low.
   function automatic logic [15:0] refRoute(input logic [15:0] d, input logic s,
                                            input logic toB, input logic r);
      int pick;
      if (r) return 16'h0000;
      pick = (s == toB) ? 1 : 0;
      return 16'(int'(d) * pick);
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic r, input logic d1, input logic s1,
                                input logic [15:0] d16, input logic s16);
      exp_t        e;
      logic [15:0] t;
      reset     = r;
      bus1.in   = d1;
      bus1.sel  = s1;
      bus16.in  = d16;
      bus16.sel = s16;
      e.tag = tag;
      t = refRoute({15'b0, d1}, s1, 1'b0, r);
      e.a1 = t[0];
      t = refRoute({15'b0, d1}, s1, 1'b1, r);
      e.b1 = t[0];
      e.a16 = refRoute(d16, s16, 1'b0, r);
      e.b16 = refRoute(d16, s16, 1'b1, r);
      sbq.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Inputs wiggle twice before settling; only the settled value should be captured.
   task automatic applyGlitch(input string tag, input logic d1, input logic s1,
                              input logic [15:0] d16, input logic s16);
      bus1.in   = ~d1;
      bus1.sel  = ~s1;
      bus16.in  = ~d16;
      bus16.sel = ~s16;
      #1;
      bus1.in   = 1'b1;
      bus16.in  = 16'hFFFF;
      #1;
      applyStimulus(tag, 1'b0, d1, s1, d16, s16);
   endtask

   // Monitor: one registered result per edge, compared 1 time unit after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput({e.tag, ".a1"},  {15'b0, bus1.a},  {15'b0, e.a1});
            checkOutput({e.tag, ".b1"},  {15'b0, bus1.b},  {15'b0, e.b1});
            checkOutput({e.tag, ".a16"}, bus16.a, e.a16);
            checkOutput({e.tag, ".b16"}, bus16.b, e.b16);
            checkOutput({e.tag, ".overlap16"}, bus16.a & bus16.b, 16'h0000);
         end
      end
   end

   initial begin
      logic        r, d1, s1, s16;
      logic [15:0] d16;

      applyStimulus("reset0", 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1);
      applyStimulus("reset1", 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1);

      applyStimulus("tt00", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      applyStimulus("tt01", 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
      applyStimulus("tt10", 1'b0, 1'b1, 1'b0, 16'h8001, 1'b0);
      applyStimulus("tt11", 1'b0, 1'b1, 1'b1, 16'h7FFE, 1'b1);

      applyStimulus("toggle0", 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
      applyStimulus("toggle1", 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
      applyStimulus("toggle2", 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);

      applyStimulus("midrst_pre",  1'b0, 1'b1, 1'b0, 16'h00FF, 1'b0);
      applyStimulus("midrst",      1'b1, 1'b1, 1'b0, 16'h00FF, 1'b0);
      applyStimulus("midrst_post", 1'b0, 1'b1, 1'b0, 16'h00FF, 1'b0);

      applyStimulus("wide_b", 1'b0, 1'b1, 1'b1, 16'hA5C3, 1'b1);
      applyStimulus("wide_a", 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b0);

      applyGlitch("glitch0", 1'b0, 1'b1, 16'h3C5A, 1'b1);
      applyGlitch("glitch1", 1'b1, 1'b0, 16'h0001, 1'b0);

      for (int i = 0; i < 300; i++) begin
         r   = ($urandom_range(15) == 0);
         d1  = 1'($urandom);
         s1  = 1'($urandom);
         d16 = 16'($urandom);
         s16 = 1'($urandom);
         if ($urandom_range(7) == 0) begin
            applyGlitch("rand_glitch", d1, s1, d16, s16);
         end else begin
            applyStimulus("rand", r, d1, s1, d16, s16);
         end
      end

      @(posedge clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain actual=%0d required=0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/h_dmux.md
# h_dmux

Registered 1-to-2 demultiplexer for the Hack computer base-gate library. The `in` value is routed to output `a` when `sel` is 0 and to output `b` when `sel` is 1. The unselected output is driven to zero. Outputs are registered on `clk` so the block can sit directly on pipeline boundaries in the ALU/CPU datapath.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of `in`, `a` and `b`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in`, input, WIDTH: data to be routed.
- `sel`, input, 1: route select. 0 selects `a`, 1 selects `b`.
- `a`, output, WIDTH: registered output; carries `in` when `sel`=0, otherwise 0.
- `b`, output, WIDTH: registered output; carries `in` when `sel`=1, otherwise 0.

## Operation
- Combinational core:
  - `a_next = sel ? {WIDTH{1'b0}} : in`
  - `b_next = sel ? in : {WIDTH{1'b0}}`
- The unselected output is always all zeros, never held at its previous value.
- On each rising edge of `clk`:
  - if `reset`=1, then `a` and `b` become 0;
  - otherwise, `a` takes `a_next` and `b` takes `b_next`.
- `a & b` is always 0 (bitwise).
  - When `sel`=0, `a | b` equals the registered `in`.
  - When `sel`=1, `a | b` also equals the registered `in`.
- There is no other state, no enable and no handshake. The block accepts a new `in`/`sel` pair every cycle.
- Width: all data paths are exactly WIDTH bits. There is no truncation or extension.

## Timing
- Latency is 1 cycle: `in`/`sel` sampled at edge N appear on `a`/`b` after edge N.
- Reset value: `a`=0, `b`=0.
  - Reset takes priority over data on the same edge.
  - Asserting `reset` mid-stream clears both outputs at the next edge, discarding the sampled input.
  - The first non-reset edge after deassertion loads the current `in`/`sel`.
- Outputs change only on clock edges. Input changes between edges are not visible on the outputs.
- A `sel` toggle with `in` constant moves the value from one output to the other in a single edge. No cycle exists where both outputs carry data.

## Structure
- The shared package holds the select encoding constants: `SEL_A`=1'b0 and `SEL_B`=1'b1. The block uses these constants rather than literal values.
- One combinational sub-module, `hdmux_core` (ports `in`, `sel`, `a`, `b`, parameter `WIDTH`), implements the routing equations.
- `h_dmux` wraps `hdmux_core` with the output register and reset logic.
- `hdmux_core` is reused unregistered by wider demux trees (DMux4Way/DMux8Way).

## Test plan
- Reset: hold `reset`=1 for 2 edges with `in`=1, `sel`=1. Required response: `a`=0, `b`=0 after each edge.
- Truth table, WIDTH=1: apply (`in`,`sel`) = (0,0), (0,1), (1,0), (1,1) on successive edges. Required response, one cycle later for each pair:
  - (0,0) gives (`a`,`b`) = (0,0);
  - (0,1) gives (0,0);
  - (1,0) gives (1,0);
  - (1,1) gives (0,1).
- Select toggle: with `in`=1, alternate `sel` 0,1,0 on successive edges. Required response: (`a`,`b`) goes (1,0), (0,1), (1,0). Both outputs are never 1 at the same time.
- Reset mid-stream: with `in`=1, `sel`=0 and `a`=1, assert `reset` for one edge. Required response:
  - `a`=0, `b`=0 after that edge;
  - `a`=1 again after the next non-reset edge.
- Wide data, WIDTH=16: drive `in`=16'hA5C3.
  - With `sel`=1, required response is `b`=16'hA5C3, `a`=16'h0000.
  - With `sel`=0, the values swap on the next edge.
- Glitch immunity: change `in` twice between edges. Required response: the outputs reflect only the value present at the edge.
